// File: rtl/sdram_aref_if.sv
// Command-bus / handshake bundle between the SDRAM auto-refresh engine and
// its controller/arbiter.
//   master : refresh engine view (drives request, status and command bus)
//   slave  : controller/arbiter view (drives init_done and grant)
// Signals: init_done, aref_en (grant), aref_req, aref_end, aref_late,
//          aref_cmd {CS_N,RAS_N,CAS_N,WE_N}, aref_ba, aref_addr[ADDR_W].
interface sdram_aref_if #(
  parameter int unsigned ADDR_W = 12
);
  logic              init_done;
  logic              aref_en;
  logic              aref_req;
  logic              aref_end;
  logic              aref_late;
  logic [3:0]        aref_cmd;
  logic [1:0]        aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  modport master (
    input  init_done, aref_en,
    output aref_req, aref_end, aref_late, aref_cmd, aref_ba, aref_addr
  );

  modport slave (
    output init_done, aref_en,
    input  aref_req, aref_end, aref_late, aref_cmd, aref_ba, aref_addr
  );
endinterface

// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh engine, downstream of sdram_init.
// Counts the refresh interval once init_done is high, requests the command
// bus (aref_req), and after a grant (aref_en) issues an optional
// PRECHARGE-ALL followed by REF_CNT AUTO REFRESH commands with tRP/tRFC NOP
// spacing, then pulses aref_end. aref_late flags an interval that elapsed
// with a request still ungranted (sticky until reset).
// Ports: clock, reset (sync, active-high), bus (sdram_aref_if.master).
// Build option: define SDRAM_AREF_PRECHARGE_EN to start each sequence with
// PRECHARGE-ALL; otherwise the sequence begins directly with AUTO REFRESH.
module sdram_aref #(
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned REF_CNT    = 2,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic         clock,
  input  logic         reset,
  sdram_aref_if.master bus
);

  localparam int unsigned INT_W  = $clog2(REF_PERIOD);
  localparam int unsigned MAX_P  = (T_RP > T_RFC) ? ((T_RP > REF_CNT) ? T_RP : REF_CNT)
                                                  : ((T_RFC > REF_CNT) ? T_RFC : REF_CNT);
  // +1 so the refresh index can reach REF_CNT itself
  localparam int unsigned WAIT_W = $clog2(MAX_P + 1);
  localparam int unsigned A10    = 10;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef SDRAM_AREF_PRECHARGE_EN
    ST_PRE,
    ST_TRP,
`endif
    ST_AREF,
    ST_TRFC,
    ST_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] idx_q, idx_d;
  logic [INT_W-1:0]  int_q, int_d;
  logic              req_q, req_d;
  logic              late_q, late_d;
  logic              end_q, end_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [1:0]        ba_q;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic grant_c;
  logic wrap_c;

  assign grant_c = (state_q == ST_IDLE) && req_q && bus.aref_en;
  assign wrap_c  = bus.init_done && (int_q == INT_W'(REF_PERIOD - 1));

  // Sequencer next state; outputs are decoded from the next state so each
  // command is registered and appears the cycle after the transition.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    cmd_d   = CMD_NOP;
    addr_d  = '1;
    end_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_c) begin
`ifdef SDRAM_AREF_PRECHARGE_EN
          state_d = ST_PRE;
`else
          state_d = ST_AREF;
`endif
        end
      end
`ifdef SDRAM_AREF_PRECHARGE_EN
      ST_PRE: begin
        wait_d  = '0;
        state_d = ST_TRP;
      end
      ST_TRP: begin
        if (wait_q == WAIT_W'(T_RP - 1)) state_d = ST_AREF;
        else                              wait_d  = wait_q + WAIT_W'(1);
      end
`endif
      ST_AREF: begin
        idx_d   = idx_q + WAIT_W'(1);
        wait_d  = '0;
        state_d = ST_TRFC;
      end
      ST_TRFC: begin
        if (wait_q == WAIT_W'(T_RFC - 1))
          state_d = (idx_q < WAIT_W'(REF_CNT)) ? ST_AREF : ST_DONE;
        else
          wait_d = wait_q + WAIT_W'(1);
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    unique case (state_d)
`ifdef SDRAM_AREF_PRECHARGE_EN
      ST_PRE: begin
        cmd_d       = CMD_PRE;
        addr_d[A10] = 1'b1;
      end
`endif
      ST_AREF: cmd_d = CMD_AREF;
      ST_DONE: end_d = 1'b1;
      default: ;
    endcase
  end

  // Interval counter, request and lateness tracking
  always_comb begin
    req_d  = req_q;
    late_d = late_q;
    int_d  = int_q + INT_W'(1);

    if (!bus.init_done || wrap_c) int_d = '0;

    // A wrap coinciding with a grant re-arms the request for the next interval
    if (wrap_c) begin
      req_d = 1'b1;
      if (req_q && !grant_c) late_d = 1'b1;
    end else if (grant_c) begin
      req_d = 1'b0;
    end

    if (!bus.init_done && (state_q == ST_IDLE)) req_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      idx_q   <= '0;
      int_q   <= '0;
      req_q   <= 1'b0;
      late_q  <= 1'b0;
      end_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      ba_q    <= 2'b11;
      addr_q  <= '1;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      int_q   <= int_d;
      req_q   <= req_d;
      late_q  <= late_d;
      end_q   <= end_d;
      cmd_q   <= cmd_d;
      ba_q    <= 2'b11;
      addr_q  <= addr_d;
    end
  end

  assign bus.aref_req  = req_q;
  assign bus.aref_end  = end_q;
  assign bus.aref_late = late_q;
  assign bus.aref_cmd  = cmd_q;
  assign bus.aref_ba   = ba_q;
  assign bus.aref_addr = addr_q;

endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: directed steps plus randomized grant timing and
// init_done drops, checked every cycle against a reference model that
// derives the expected command from the offset since the grant.
module tb_sdram_aref;

  localparam int REF_PERIOD = 780;
  localparam int T_RP       = 2;
  localparam int T_RFC      = 7;
  localparam int REF_CNT    = 2;
  localparam int ADDR_W     = 12;

`ifdef SDRAM_AREF_PRECHARGE_EN
  localparam bit PRE_EN = 1'b1;
`else
  localparam bit PRE_EN = 1'b0;
`endif

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  // Offset (cycles after grant) of the first AUTO REFRESH and of aref_end
  localparam int FIRST   = PRE_EN ? (2 + T_RP) : 1;
  localparam int END_OFF = FIRST + REF_CNT * (T_RFC + 1);

  logic clk;
  logic rst;

  sdram_aref_if #(.ADDR_W(ADDR_W)) bus ();

  sdram_aref #(
    .REF_PERIOD(REF_PERIOD),
    .T_RP      (T_RP),
    .T_RFC     (T_RFC),
    .REF_CNT   (REF_CNT),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int m_ticks = 0;
  bit m_req   = 1'b0;
  bit m_late  = 1'b0;
  int m_pos   = 0;

  function automatic logic [3:0] cmd_at(int p);
    if (p == 0) return NOP;
    if (PRE_EN && p == 1) return PRE;
    if (p >= FIRST && p < END_OFF && ((p - FIRST) % (T_RFC + 1)) == 0) return AREF;
    return NOP;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model over one edge, clock the DUT, then compare all outputs
  task automatic step();
    bit active, grant, wrap;
    logic [31:0] exp_v, obs_v;
    if (rst) begin
      m_ticks = 0;
      m_req   = 1'b0;
      m_late  = 1'b0;
      m_pos   = 0;
    end else begin
      active  = (m_pos != 0);
      grant   = !active && m_req && (bus.aref_en === 1'b1);
      wrap    = (bus.init_done === 1'b1) && (m_ticks == REF_PERIOD - 1);
      m_ticks = (bus.init_done === 1'b1) ? (m_ticks + 1) % REF_PERIOD : 0;
      if (wrap) begin
        if (m_req && !grant) m_late = 1'b1;
        m_req = 1'b1;
      end else if (grant) begin
        m_req = 1'b0;
      end
      if ((bus.init_done !== 1'b1) && !active) m_req = 1'b0;
      if (grant)       m_pos = 1;
      else if (active) m_pos = (m_pos == END_OFF) ? 0 : m_pos + 1;
    end
    @(posedge clk);
    #1;
    exp_v = 32'({cmd_at(m_pos), 2'b11, {ADDR_W{1'b1}}, m_req, (m_pos == END_OFF), m_late});
    obs_v = 32'({bus.aref_cmd, bus.aref_ba, bus.aref_addr,
                 bus.aref_req, bus.aref_end, bus.aref_late});
    chk("outputs", obs_v, exp_v);
  endtask

  task automatic wait_req(input int bound, output int n);
    n = 0;
    while (bus.aref_req !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    chk("req_wait", 32'(bus.aref_req), 32'd1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    int end_cnt;
    int end_at;

    rst           = 1'b1;
    bus.init_done = 1'b0;
    bus.aref_en   = 1'b0;

    // Reset, then a long stretch with the device not yet initialised
    repeat (3) step();
    rst = 1'b0;
    repeat (1000) step();
    chk("idle_cmd", 32'(bus.aref_cmd), 32'(NOP));
    chk("idle_req", 32'(bus.aref_req), 32'd0);

    // Interval timing and the late flag with no grant
    bus.init_done = 1'b1;
    wait_req(REF_PERIOD + 50, n);
    chk("req_latency", 32'(n), 32'(REF_PERIOD));
    repeat (REF_PERIOD - 1) step();
    chk("late_not_yet", 32'(bus.aref_late), 32'd0);
    step();
    chk("late_set", 32'(bus.aref_late), 32'd1);

    // Grant on the first request, grant held high through the sequence
    pulse_reset();
    wait_req(REF_PERIOD + 50, n);
    bus.aref_en = 1'b1;
    step();
    chk("first_cmd", 32'(bus.aref_cmd), 32'(PRE_EN ? PRE : AREF));
    chk("first_a10", 32'(bus.aref_addr[10]), 32'd1);
    end_cnt = 0;
    end_at  = 0;
    for (int k = 2; k <= END_OFF + 5; k++) begin
      step();
      if (bus.aref_end === 1'b1) begin
        end_cnt++;
        end_at = k;
      end
    end
    bus.aref_en = 1'b0;
    chk("end_pulses", 32'(end_cnt), 32'd1);
    chk("end_offset", 32'(end_at), 32'(END_OFF));

    // Grant on the exact wrap cycle: request re-armed, no lateness
    pulse_reset();
    wait_req(REF_PERIOD + 50, n);
    cnt = 0;
    while (m_ticks != REF_PERIOD - 1 && cnt < REF_PERIOD + 10) begin
      step();
      cnt++;
    end
    bus.aref_en = 1'b1;
    step();
    bus.aref_en = 1'b0;
    chk("wrap_grant_req", 32'(bus.aref_req), 32'd1);
    chk("wrap_grant_late", 32'(bus.aref_late), 32'd0);
    repeat (END_OFF + 2) step();
    chk("wrap_req_held", 32'(bus.aref_req), 32'd1);
    chk("wrap_late_clear", 32'(bus.aref_late), 32'd0);
    bus.aref_en = 1'b1;
    step();
    bus.aref_en = 1'b0;
    repeat (END_OFF + 2) step();

    // Reset mid-sequence at g+6
    pulse_reset();
    wait_req(REF_PERIOD + 50, n);
    bus.aref_en = 1'b1;
    step();
    bus.aref_en = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("midrst_cmd", 32'(bus.aref_cmd), 32'(NOP));
    chk("midrst_req", 32'(bus.aref_req), 32'd0);
    rst = 1'b0;
    end_cnt = 0;
    for (int k = 0; k < END_OFF + 5; k++) begin
      step();
      if (bus.aref_end === 1'b1) end_cnt++;
    end
    chk("midrst_no_end", 32'(end_cnt), 32'd0);
    wait_req(REF_PERIOD + 50, n);
    chk("midrst_req_latency", 32'(n + END_OFF + 5), 32'(REF_PERIOD));

    // Randomized grant delays, grant hold times and init_done drops
    pulse_reset();
    for (int it = 0; it < 12; it++) begin
      wait_req(2 * REF_PERIOD + 100, n);
      repeat ($urandom_range(0, 900)) step();
      bus.aref_en = 1'b1;
      repeat ($urandom_range(1, 25)) step();
      bus.aref_en = 1'b0;
      if (it % 3 == 2) begin
        repeat ($urandom_range(0, 10)) step();
        bus.init_done = 1'b0;
        repeat ($urandom_range(3, 40)) step();
        bus.init_done = 1'b1;
      end
      repeat ($urandom_range(0, 30)) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
